instr_fetch_mem: RTL

Parametrised, byte-addressed instruction memory with a valid/ready fetch port, one registered read stage, a byte-wide loader port, and optional alignment/bounds checking. It sits between the PC/fetch logic and decode, replacing the combinational instruction ROM. It adds real backpressure, runtime program loading and a fetch counter so pipelined cores can stall fetch.

---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/imem_byte_ram.sv | 48 ++++
 rtl/instr_fetch_mem.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared constants and types for the instruction fetch memory.
//   INST_W            : instruction width (the only supported value is 32)
//   IFETCH_ADDR_W_MAX : widest fetch address the response record can carry
//   IFETCH_NOP        : instruction returned in place of a faulting fetch
//   fetch_rsp_t       : registered response record {inst, addr, err}
// ----------------------------------------------------------------------------
package ifetch_pkg;

   localparam int INST_W            = 32;
   localparam int IFETCH_ADDR_W_MAX = 64;

   localparam logic [INST_W-1:0] IFETCH_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [INST_W-1:0]            inst;
      logic [IFETCH_ADDR_W_MAX-1:0] addr;
      logic                         err;
   } fetch_rsp_t;

endpackage

// File: rtl/imem_byte_ram.sv
// ----------------------------------------------------------------------------
// imem_byte_ram
// Byte-wide storage with one synchronous byte write port and a combinational
// 4-byte little-endian read that wraps around the end of the array.
// Contents are never reset.
//   clk     in  : write clock (rising edge)
//   wr_en   in  : write strobe
//   wr_idx  in  : byte index to write
//   wr_data in  : byte to write
//   rd_idx  in  : index of the lowest byte of the word to read
//   rd_word out : {mem[i+3], mem[i+2], mem[i+1], mem[i]} (indices modulo depth)
// ----------------------------------------------------------------------------
module imem_byte_ram #(
   parameter int DEPTH_BYTES = 256,
   parameter int IDX_W       = 8
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_word
);

   logic [7:0] mem_r [DEPTH_BYTES];

   // Offsets are computed at IDX_W bits so they wrap modulo the depth for free.
   logic [IDX_W-1:0] idx1_s;
   logic [IDX_W-1:0] idx2_s;
   logic [IDX_W-1:0] idx3_s;

   assign idx1_s = rd_idx + IDX_W'(1'b1);
   assign idx2_s = rd_idx + IDX_W'(2'd2);
   assign idx3_s = rd_idx + IDX_W'(2'd3);

   // Loader byte write; storage is intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_idx] <= wr_data;
      end
   end

   // Little-endian word assembly.
   always_comb begin
      rd_word = {mem_r[idx3_s], mem_r[idx2_s], mem_r[idx1_s], mem_r[rd_idx]};
   end

endmodule

// File: rtl/instr_fetch_mem.sv
// ----------------------------------------------------------------------------
// instr_fetch_mem
// Byte-addressed instruction memory with a valid/ready fetch port, one
// registered response stage, a byte loader port and a saturating fetch count.
//
// Build option: define IFETCH_BOUNDS_CHECK_EN to flag misaligned or
// out-of-range fetches on rsp_err (instruction replaced by NOP). Without it
// rsp_err is 0 and addresses wrap modulo DEPTH_BYTES.
//
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   req_valid/ready   : fetch request handshake (req_ready is combinational)
//   req_addr          : byte address of the instruction
//   rsp_valid/ready   : response handshake (response is registered)
//   rsp_inst          : little-endian instruction word
//   rsp_addr          : echo of the accepted request address
//   rsp_err           : fetch fault (bounds-check build only)
//   ld_en/addr/data   : loader byte write; has priority over fetches
//   fetch_count       : saturating count of accepted fetches
// ----------------------------------------------------------------------------
module instr_fetch_mem #(
   parameter int ADDR_W      = 64,
   parameter int DEPTH_BYTES = 256,
   parameter int INST_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [INST_W-1:0] rsp_inst,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_err,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   output logic [31:0]       fetch_count
);

   import ifetch_pkg::*;

   localparam int IDX_W = $clog2(DEPTH_BYTES);

   // Elaboration-time parameter sanity.
   if (INST_W != ifetch_pkg::INST_W) begin : g_bad_inst_w
      $error("instr_fetch_mem: INST_W must be 32");
   end
   if ((DEPTH_BYTES < 4) || ((DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0)) begin : g_bad_depth
      $error("instr_fetch_mem: DEPTH_BYTES must be a power of two >= 4");
   end
   if ((ADDR_W <= IDX_W) || (ADDR_W > IFETCH_ADDR_W_MAX)) begin : g_bad_addr_w
      $error("instr_fetch_mem: ADDR_W must exceed the index width and be <= 64");
   end

   logic              accept_s;
   logic [IDX_W-1:0]  rd_idx_s;
   logic [IDX_W-1:0]  wr_idx_s;
   logic [31:0]       rd_word_s;
   fetch_rsp_t        rsp_next_s;
   fetch_rsp_t        rsp_r;
   logic              rsp_valid_r;
   logic [31:0]       fetch_count_r;
   logic              unused_ld_hi_s;

   assign rd_idx_s = req_addr[IDX_W-1:0];
   assign wr_idx_s = ld_addr[IDX_W-1:0];

   // Loader addresses wrap modulo the depth, so the high bits carry no meaning.
   assign unused_ld_hi_s = ^ld_addr[ADDR_W-1:IDX_W];

   imem_byte_ram #(
      .DEPTH_BYTES (DEPTH_BYTES),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ld_en),
      .wr_idx  (wr_idx_s),
      .wr_data (ld_data),
      .rd_idx  (rd_idx_s),
      .rd_word (rd_word_s)
   );

   // Loader wins; otherwise accept whenever the response slot is free or draining.
   assign req_ready = !ld_en && (!rsp_valid_r || rsp_ready);
   assign accept_s  = req_valid && req_ready;

`ifdef IFETCH_BOUNDS_CHECK_EN
   logic misalign_s;
   logic out_of_range_s;

   assign misalign_s     = (req_addr[1:0] != 2'b00);
   assign out_of_range_s = |req_addr[ADDR_W-1:IDX_W];
`endif

   // Next response record: hold unless a request is accepted this cycle.
   always_comb begin
      rsp_next_s = rsp_r;
      if (accept_s) begin
         rsp_next_s.addr = IFETCH_ADDR_W_MAX'(req_addr);
`ifdef IFETCH_BOUNDS_CHECK_EN
         if (misalign_s || out_of_range_s) begin
            rsp_next_s.err  = 1'b1;
            rsp_next_s.inst = IFETCH_NOP;
         end else begin
            rsp_next_s.err  = 1'b0;
            rsp_next_s.inst = rd_word_s;
         end
`else
         rsp_next_s.err  = 1'b0;
         rsp_next_s.inst = rd_word_s;
`endif
      end else begin
         rsp_next_s = rsp_r;
      end
   end

   // Response register, valid flag and saturating fetch counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_r         <= '0;
         rsp_valid_r   <= 1'b0;
         fetch_count_r <= 32'd0;
      end else begin
         rsp_r <= rsp_next_s;
         if (accept_s) begin
            rsp_valid_r <= 1'b1;
            if (fetch_count_r != 32'hFFFF_FFFF) begin
               fetch_count_r <= fetch_count_r + 32'd1;
            end
         end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
         end
      end
   end

   assign rsp_valid   = rsp_valid_r;
   assign rsp_inst    = rsp_r.inst;
   assign rsp_addr    = rsp_r.addr[ADDR_W-1:0];
   assign rsp_err     = rsp_r.err;
   assign fetch_count = fetch_count_r;

endmodule
